id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Produces the `freeze` and `flush` controls consumed by the ID→EXE pipeline register of the 5-stage ARM core (IF, ID, EXE, MEM, WB).
- Tracks in-flight register writes with a per-register pending scoreboard, from ID-stage issue until WB retire.
- Freezes the ID stage on RAW hazards and on scoreboard saturation.
- Flushes on a taken branch resolved in EXE, and keeps a saturating stall-cycle counter.

Parameters:
- NUM_REGS, 16, architectural registers tracked
- REG_W, 4, register index width
- CNT_W, 2, pending-counter width per register (max 3 in flight)
- PERF_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_src1  in  REG_W  first source register (Rn)
- id_src2  in  REG_W  second source register (Rm, or Rd for STR)
- id_two_src  in  1  id_src2 is read
- id_wb_en  in  1  instruction writes id_dest
- id_dest  in  REG_W  destination register
- id_mem_read  in  1  instruction is a load
- exe_branch_taken  in  1  branch in EXE taken this cycle
- wb_en  in  1  WB stage writes the register file this cycle
- wb_dest  in  REG_W  WB destination
- freeze  out  1  hold IF and ID, insert bubble
- flush  out  1  clear the ID→EXE register at the next edge
- hazard  out  1  raw hazard indication (before branch override)
- pending_mask  out  NUM_REGS  bit i = 1 iff pend[i] != 0
- stall_count  out  PERF_W  number of cycles with freeze = 1

Behaviour:
- Reset (async, rst=1):
  - all pend[i]=0; stall_count=0; exe-load tracker cleared.
  - freeze, flush and hazard are forced to 0 while rst is high.
- Combinational outputs, same cycle:
  - `hazard` = id_valid & ( pend[id_src1]!=0 | (id_two_src & pend[id_src2]!=0) | (id_wb_en & pend[id_dest]==max) ).
  - `flush` = exe_branch_taken.
  - `freeze` = hazard & ~exe_branch_taken. Branch overrides the stall; the squashed ID instruction never stalls.
- Issue event: id_valid & id_wb_en & ~freeze & ~flush. Increments pend[id_dest] at the next edge.
- Retire event: wb_en. Decrements pend[wb_dest] at the next edge.
  - A counter at 0 stays at 0: underflow is clamped.
- Issue and retire to the same register in one cycle: counter unchanged.
  - Different registers: both update.
- No WB→ID bypass:
  - A retire clears a hazard only from the following cycle.
  - Latency from wb_en to freeze deassert is 1 cycle.
- Saturation: a writer whose dest counter equals max (3) is frozen until a retire of that register. The counter never wraps.
- stall_count: +1 on every edge where freeze=1; holds at all-ones.
- Frozen or flushed cycles never update the scoreboard from the ID side. WB retires are always processed.
- Reset mid-operation: all state cleared immediately. In-flight instructions are considered discarded.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - Source hazards use load-use detection only.
  - Extra stage register {exe_ld_v, exe_ld_dest} captures id_mem_read & id_wb_en & id_dest on an issue event. It is cleared (bubble) when freeze or flush is 1.
  - hazard = id_valid & exe_ld_v & (id_src1==exe_ld_dest | (id_two_src & id_src2==exe_ld_dest)), OR the saturation term.
  - Scoreboard and pending_mask are still maintained.
- Undefined: full scoreboard stalling as described above. The exe-load tracker is not implemented.

Test Plan:
- Reset: assert rst mid-cycle with pend[3]=2.
  - freeze=flush=hazard=0 immediately; pending_mask=0, stall_count=0 after release.
- RAW stall:
  - Issue ADD R1 (wb_en, dest=1); next cycle SUB reads src1=1.
  - freeze=1 until a wb_en, wb_dest=1 cycle, deasserts one cycle after.
  - stall_count equals the number of frozen cycles (3 for a 5-stage path).
- Branch override: hazard condition true plus exe_branch_taken=1 in the same cycle.
  - flush=1, freeze=0, hazard=1.
  - pend[id_dest] not incremented.
- Same-cycle issue and retire to R5 with pend[5]=1: pend[5] stays 1, pending_mask[5]=1.
  - Retire only: counter 0, bit clears.
- Saturation: three unretired writers to R7 (pend[7]=3), fourth writer to R7 with independent sources.
  - freeze=1 until a retire of R7, then the writer issues and pend[7]=3.
- FORWARDING_EN defined:
  - LDR R2 then ADD src1=2: exactly 1 freeze cycle.
  - ADD R2 then ADD src1=2: 0 freeze cycles.

Source files
------------

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard control bus.
// Groups the ID-stage issue fields, EXE branch resolution, WB retire port and the
// resulting pipeline controls into one bundle.
//   master : pipeline side, drives ID/EXE/WB info and receives freeze/flush/status
//   slave  : hazard controller side
interface id_hazard_ctrl_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned PERF_W   = 16
);
    logic                id_valid;
    logic [REG_W-1:0]    id_src1;
    logic [REG_W-1:0]    id_src2;
    logic                id_two_src;
    logic                id_wb_en;
    logic [REG_W-1:0]    id_dest;
    logic                id_mem_read;
    logic                exe_branch_taken;
    logic                wb_en;
    logic [REG_W-1:0]    wb_dest;
    logic                freeze;
    logic                flush;
    logic                hazard;
    logic [NUM_REGS-1:0] pending_mask;
    logic [PERF_W-1:0]   stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_read,
        output exe_branch_taken, wb_en, wb_dest,
        input  freeze, flush, hazard, pending_mask, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_read,
        input  exe_branch_taken, wb_en, wb_dest,
        output freeze, flush, hazard, pending_mask, stall_count
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller for the 5-stage core.
// Keeps a per-register pending-write scoreboard (issue in ID, retire in WB), raises
// freeze on RAW hazards or scoreboard saturation, raises flush on a taken EXE branch,
// and counts frozen cycles in a saturating counter.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : id_hazard_ctrl_if.slave (ID issue info, branch, WB retire in;
//          freeze, flush, hazard, pending_mask, stall_count out)
// Build option:
//   FORWARDING_EN : source hazards reduced to load-use detection via an EXE-load
//                   tracker; scoreboard and saturation stalling still apply.
module id_hazard_ctrl #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned PERF_W   = 16
) (
    input logic              clk,
    input logic              rst,
    id_hazard_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0]    pend_q [NUM_REGS];
    logic [CNT_W-1:0]    pend_d [NUM_REGS];
    logic [PERF_W-1:0]   stall_q;
    logic [NUM_REGS-1:0] mask;

    logic src_hit;
    logic sat_hit;
    logic hazard;
    logic flush;
    logic freeze;
    logic issue;
    logic inc;
    logic dec;

`ifdef FORWARDING_EN
    logic             exe_ld_v_q;
    logic [REG_W-1:0] exe_ld_dest_q;
`endif

    // A writer whose destination counter is full must wait for a retire.
    assign sat_hit = bus.id_wb_en & (pend_q[bus.id_dest] == CntMax);

`ifdef FORWARDING_EN
    // Only a load still in EXE cannot be forwarded in time.
    assign src_hit = exe_ld_v_q & ((bus.id_src1 == exe_ld_dest_q) |
                                   (bus.id_two_src & (bus.id_src2 == exe_ld_dest_q)));
`else
    assign src_hit = (pend_q[bus.id_src1] != '0) |
                     (bus.id_two_src & (pend_q[bus.id_src2] != '0));
`endif

    // Outputs are gated by rst so they read 0 immediately while reset is held.
    assign hazard = ~rst & bus.id_valid & (src_hit | sat_hit);
    assign flush  = ~rst & bus.exe_branch_taken;
    assign freeze = hazard & ~bus.exe_branch_taken;
    assign issue  = bus.id_valid & bus.id_wb_en & ~freeze & ~flush;

    always_comb begin
        inc  = 1'b0;
        dec  = 1'b0;
        mask = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc       = issue && (bus.id_dest == REG_W'(i));
            dec       = bus.wb_en && (bus.wb_dest == REG_W'(i));
            pend_d[i] = pend_q[i];
            // Issue and retire to the same register cancel out; retire at 0 is clamped.
            if (inc && !dec) begin
                pend_d[i] = pend_q[i] + 1'b1;
            end else if (dec && !inc && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
            mask[i] = (pend_q[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
            if (freeze && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

`ifdef FORWARDING_EN
    // EXE-load tracker: a bubble (freeze/flush) or any non-load advance clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_ld_v_q    <= 1'b0;
            exe_ld_dest_q <= '0;
        end else if (freeze || flush) begin
            exe_ld_v_q    <= 1'b0;
        end else begin
            exe_ld_v_q    <= issue & bus.id_mem_read;
            exe_ld_dest_q <= bus.id_dest;
        end
    end
`endif

    assign bus.hazard       = hazard;
    assign bus.flush        = flush;
    assign bus.freeze       = freeze;
    assign bus.pending_mask = mask;
    assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl_if #(.NUM_REGS(16), .REG_W(4), .PERF_W(16)) bus ();

    id_hazard_ctrl #(.NUM_REGS(16), .REG_W(4), .CNT_W(2), .PERF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        two;
        logic        wbe;
        logic [3:0]  dest;
        logic        mem;
        logic        br;
        logic        wb;
        logic [3:0]  wbd;
        logic        hz;
        logic        fz;
        logic        fl;
        logic [15:0] mask;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(logic valid, logic [3:0] src1, logic [3:0] src2, logic two,
                                logic wbe, logic [3:0] dest, logic mem, logic br, logic wb,
                                logic [3:0] wbd, logic hz, logic fz, logic fl,
                                logic [15:0] mask, logic [15:0] stall);
        vec_t v;
        v.valid = valid; v.src1 = src1; v.src2 = src2; v.two = two; v.wbe = wbe;
        v.dest = dest; v.mem = mem; v.br = br; v.wb = wb; v.wbd = wbd;
        v.hz = hz; v.fz = fz; v.fl = fl; v.mask = mask; v.stall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [3:0] src1, input logic [3:0] src2,
                         input logic two, input logic wbe, input logic [3:0] dest,
                         input logic mem, input logic br, input logic wb,
                         input logic [3:0] wbd);
        bus.id_valid = valid; bus.id_src1 = src1; bus.id_src2 = src2;
        bus.id_two_src = two; bus.id_wb_en = wbe; bus.id_dest = dest;
        bus.id_mem_read = mem; bus.exe_branch_taken = br; bus.wb_en = wb;
        bus.wb_dest = wbd;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nfz;

    initial begin
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_mask", 32'(bus.pending_mask), 32'h0);
        chk("reset_stall", 32'(bus.stall_count), 32'h0);
        chk("reset_freeze", 32'(bus.freeze), 32'h0);
        tick();

`ifndef FORWARDING_EN
        //                  vld s1 s2 two wbe dst mem br wb wbd   hz fz fl mask     stall
        vecs[0]  = mk(1, 2, 3, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 16'h0002, 16'd0);
        vecs[1]  = mk(1, 1, 0, 0, 1, 4, 0, 0, 0, 0,  1, 1, 0, 16'h0002, 16'd1);
        vecs[2]  = mk(1, 1, 0, 0, 1, 4, 0, 0, 0, 0,  1, 1, 0, 16'h0002, 16'd2);
        vecs[3]  = mk(1, 1, 0, 0, 1, 4, 0, 0, 1, 1,  1, 1, 0, 16'h0000, 16'd3);
        vecs[4]  = mk(1, 1, 0, 0, 1, 4, 0, 0, 0, 0,  0, 0, 0, 16'h0010, 16'd3);
        vecs[5]  = mk(1, 4, 0, 0, 1, 6, 0, 1, 0, 0,  1, 0, 1, 16'h0010, 16'd3);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  0, 0, 0, 16'h0000, 16'd3);
        vecs[7]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 0, 16'h0020, 16'd3);
        vecs[8]  = mk(1, 0, 0, 0, 1, 5, 0, 0, 1, 5,  0, 0, 0, 16'h0020, 16'd3);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 0, 16'h0000, 16'd3);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 0, 16'h0000, 16'd3);
        vecs[11] = mk(1, 0, 0, 1, 1, 7, 0, 0, 0, 0,  0, 0, 0, 16'h0080, 16'd3);
        vecs[12] = mk(1, 0, 0, 1, 1, 7, 0, 0, 0, 0,  0, 0, 0, 16'h0080, 16'd3);
        vecs[13] = mk(1, 0, 0, 1, 1, 7, 0, 0, 0, 0,  0, 0, 0, 16'h0080, 16'd3);
        vecs[14] = mk(1, 0, 0, 1, 1, 7, 0, 0, 0, 0,  1, 1, 0, 16'h0080, 16'd4);
        vecs[15] = mk(1, 0, 0, 1, 1, 7, 0, 0, 1, 7,  1, 1, 0, 16'h0080, 16'd5);
        vecs[16] = mk(1, 0, 0, 1, 1, 7, 0, 0, 0, 0,  0, 0, 0, 16'h0080, 16'd5);
        vecs[17] = mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0080, 16'd5);
        vecs[18] = mk(1, 0, 7, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 16'h0080, 16'd6);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].valid, vecs[i].src1, vecs[i].src2, vecs[i].two, vecs[i].wbe,
                  vecs[i].dest, vecs[i].mem, vecs[i].br, vecs[i].wb, vecs[i].wbd);
            #1;
            chk($sformatf("v%0d_hazard", i), 32'(bus.hazard), 32'(vecs[i].hz));
            chk($sformatf("v%0d_freeze", i), 32'(bus.freeze), 32'(vecs[i].fz));
            chk($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].fl));
            tick();
            chk($sformatf("v%0d_mask", i), 32'(bus.pending_mask), 32'(vecs[i].mask));
            chk($sformatf("v%0d_stall", i), 32'(bus.stall_count), 32'(vecs[i].stall));
        end

        // pend[7] was left at 3: it takes exactly three retires to clear.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7);
            tick();
            chk($sformatf("drain7_%0d", i), 32'(bus.pending_mask),
                (i == 2) ? 32'h0 : 32'h80);
        end
`else
        // Load-use: LDR R2 then ADD reading R2 -> exactly one frozen cycle.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 4'd0);
        nfz = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!bus.freeze) break;
            nfz++;
            tick();
        end
        chk("ldr_use_freezes", 32'(nfz), 32'd1);
        tick();
        chk("ldr_use_mask", 32'(bus.pending_mask), 32'h0104);
        chk("ldr_use_stall", 32'(bus.stall_count), 32'd1);
        // ALU result forwarded: ADD R2 then ADD reading R2 -> no freeze.
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0);
        nfz = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!bus.freeze) break;
            nfz++;
            tick();
        end
        chk("alu_use_freezes", 32'(nfz), 32'd0);
        tick();
        chk("alu_use_stall", 32'(bus.stall_count), 32'd1);
`endif

        // Mid-cycle reset with pend[3]=2 (second writer is a load so both builds hazard).
        idle();
        tick();
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        chk("pre_rst_mask", 32'(bus.pending_mask & 16'h0008), 32'h8);
        drive(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        chk("pre_rst_hazard", 32'(bus.hazard), 32'h1);
        #2;
        rst = 1'b1;
        bus.exe_branch_taken = 1'b1;
        #1;
        chk("rst_hazard", 32'(bus.hazard), 32'h0);
        chk("rst_freeze", 32'(bus.freeze), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        tick();
        idle();
        rst = 1'b0;
        #1;
        chk("post_rst_mask", 32'(bus.pending_mask), 32'h0);
        chk("post_rst_stall", 32'(bus.stall_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
